// File: rtl/alarm_unit_pkg.sv
// Package: alarm_unit_pkg
// Shared definitions for the alarm stage.
//  - alarm_state_t : FSM state encoding (DISARMED, ARMED, RINGING, SNOOZED)
//  - SEC_MAX, MIN_MAX, HOUR_MAX : largest legal value of each time field
//  - time_ok()     : true when an hh:mm pair is a legal time of day
package alarm_unit_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZED  = 2'd3
  } alarm_state_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  function automatic logic time_ok(input logic [4:0] h, input logic [5:0] m);
    return (h <= 5'(HOUR_MAX)) && (m <= 6'(MIN_MAX));
  endfunction

endpackage

// File: rtl/alarm_unit_if.sv
// Interface: alarm_unit_if
// Valid/ready load channel for a new alarm time.
//  set_valid  master -> slave  request to load set_hour:set_min
//  set_hour   master -> slave  requested alarm hour
//  set_min    master -> slave  requested alarm minute
//  set_ready  slave -> master  the alarm stage can take a load this cycle
interface alarm_unit_if;

  logic       set_valid;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       set_ready;

  modport master (
    output set_valid,
    output set_hour,
    output set_min,
    input  set_ready
  );

  modport slave (
    input  set_valid,
    input  set_hour,
    input  set_min,
    output set_ready
  );

endinterface

// File: rtl/alarm_unit_time_add_min.sv
// Module: time_add_min
// Combinational hh:mm + ADD_MIN minutes. Minutes wrap mod 60 with a carry
// into the hour, hours wrap mod 24 (23:58 + 5 = 00:03).
// Only built when ALARM_SNOOZE_EN is defined, since the snooze target is
// its sole user.
//  hour      in   5  hour 0..23
//  min       in   6  minute 0..59
//  sum_hour  out  5  resulting hour
//  sum_min   out  6  resulting minute
`ifdef ALARM_SNOOZE_EN
module time_add_min
  import alarm_unit_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [4:0] hour,
  input  logic [5:0] min,
  output logic [4:0] sum_hour,
  output logic [5:0] sum_min
);

  logic [6:0] min_sum;
  logic       carry;

  // ADD_MIN is at most 59, so at most one minute wrap can occur.
  always_comb begin
    min_sum = 7'(min) + 7'(ADD_MIN);
    carry   = (min_sum > 7'(MIN_MAX));
    sum_min = carry ? 6'(min_sum - 7'(MIN_MAX + 1)) : min_sum[5:0];
    if (carry && (hour == 5'(HOUR_MAX))) begin
      sum_hour = '0;
    end else begin
      sum_hour = hour + {4'b0000, carry};
    end
  end

endmodule
`endif

// File: rtl/alarm_unit.sv
// Module: alarm_unit
// Alarm stage fed by the hh:mm:ss time counter. Holds a programmable alarm
// time, rings when the time reaches alarm_hour:alarm_min:00, and supports
// stop, snooze (bounded by MAX_SNOOZE) and auto-silence after RING_MAX_SEC
// ringing seconds.
// Build option: ALARM_SNOOZE_EN enables the snooze feature. Without it the
// snooze input is ignored and the SNOOZED state is never entered.
// Ports:
//  clk, rst          clock (rising edge), asynchronous active-low reset
//  sec/min/hour      current time from the time counter
//  arm               level, 1 = alarm enabled
//  set               alarm_unit_if slave: alarm time load handshake
//  stop, snooze      single-cycle user pulses
//  alarm_hour/min    stored alarm time
//  ringing           alarm active
//  alarm_hit         pulse on every entry to RINGING
//  ring_tmo          pulse on auto-silence
//  cfg_err           pulse when a load carries an illegal time
module alarm_unit
  import alarm_unit_pkg::*;
#(
  parameter int RST_HOUR     = 6,
  parameter int RST_MIN      = 0,
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_MAX_SEC = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sec,
  input  logic [5:0]  min,
  input  logic [4:0]  hour,
  input  logic        arm,
  alarm_unit_if.slave set,
  input  logic        stop,
  input  logic        snooze,
  output logic [4:0]  alarm_hour,
  output logic [5:0]  alarm_min,
  output logic        ringing,
  output logic        alarm_hit,
  output logic        ring_tmo,
  output logic        cfg_err
);

  alarm_state_t state;
  logic [5:0]   sec_q;
  logic [7:0]   ring_cnt;
  logic         ready_q;
  logic         sec_tick;
  logic         load_fire;
  logic         load_ok;
  logic [4:0]   tgt_hour;
  logic [5:0]   tgt_min;
  logic         match;
  logic         ring_last;

  // Any change of the seconds field is a tick, so the counter may advance
  // every clock or only on enables.
  assign sec_tick  = (sec != sec_q);
  assign load_fire = set.set_valid && ready_q;
  assign load_ok   = load_fire && time_ok(set.set_hour, set.set_min);
  assign match     = sec_tick && (sec == 6'd0) && (hour == tgt_hour) && (min == tgt_min);
  assign ring_last = sec_tick && (ring_cnt == 8'(RING_MAX_SEC - 1));
  assign set.set_ready = ready_q;

`ifdef ALARM_SNOOZE_EN
  logic [4:0] snz_hour;
  logic [5:0] snz_min;
  logic [4:0] nxt_snz_hour;
  logic [5:0] nxt_snz_min;
  logic [7:0] snooze_cnt;
  logic       snooze_ok;

  time_add_min #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_snz_add (
    .hour     (hour),
    .min      (min),
    .sum_hour (nxt_snz_hour),
    .sum_min  (nxt_snz_min)
  );

  assign snooze_ok = snooze && (snooze_cnt < 8'(MAX_SNOOZE));
  assign tgt_hour  = (state == ST_SNOOZED) ? snz_hour : alarm_hour;
  assign tgt_min   = (state == ST_SNOOZED) ? snz_min  : alarm_min;
`else
  logic snooze_unused;

  assign snooze_unused = snooze ^ (MAX_SNOOZE != 0) ^ (SNOOZE_MIN != 0);
  assign tgt_hour      = alarm_hour;
  assign tgt_min       = alarm_min;
`endif

  // Stored alarm time and load result. A match in the same cycle as a load
  // still compares against the old value because this register updates at
  // the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_hour <= 5'(RST_HOUR);
      alarm_min  <= 6'(RST_MIN);
      cfg_err    <= 1'b0;
      sec_q      <= '0;
    end else begin
      sec_q   <= sec;
      cfg_err <= load_fire && !load_ok;
      if (load_ok) begin
        alarm_hour <= set.set_hour;
        alarm_min  <= set.set_min;
      end
    end
  end

  // Alarm FSM. ringing and set_ready are registered alongside the state so
  // they always describe the state just entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_DISARMED;
      ringing   <= 1'b0;
      ready_q   <= 1'b1;
      alarm_hit <= 1'b0;
      ring_tmo  <= 1'b0;
      ring_cnt  <= '0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt <= '0;
      snz_hour   <= '0;
      snz_min    <= '0;
`endif
    end else begin
      alarm_hit <= 1'b0;
      ring_tmo  <= 1'b0;
      if (!arm) begin
        state   <= ST_DISARMED;
        ringing <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        case (state)
          ST_DISARMED: begin
            state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (match) begin
              state     <= ST_RINGING;
              ringing   <= 1'b1;
              ready_q   <= 1'b0;
              alarm_hit <= 1'b1;
              ring_cnt  <= '0;
`ifdef ALARM_SNOOZE_EN
              snooze_cnt <= '0;
`endif
            end
          end
          ST_RINGING: begin
            if (stop) begin
              state   <= ST_ARMED;
              ringing <= 1'b0;
              ready_q <= 1'b1;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze_ok) begin
              state      <= ST_SNOOZED;
              ringing    <= 1'b0;
              ready_q    <= 1'b1;
              snooze_cnt <= snooze_cnt + 8'd1;
              snz_hour   <= nxt_snz_hour;
              snz_min    <= nxt_snz_min;
`endif
            end else if (ring_last) begin
              state    <= ST_ARMED;
              ringing  <= 1'b0;
              ready_q  <= 1'b1;
              ring_tmo <= 1'b1;
            end else if (sec_tick) begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
`ifdef ALARM_SNOOZE_EN
          ST_SNOOZED: begin
            // A due snooze ring takes precedence over a load arriving in
            // the same cycle; otherwise a load drops the snooze.
            if (stop) begin
              state <= ST_ARMED;
            end else if (match) begin
              state     <= ST_RINGING;
              ringing   <= 1'b1;
              ready_q   <= 1'b0;
              alarm_hit <= 1'b1;
              ring_cnt  <= '0;
            end else if (load_ok) begin
              state <= ST_ARMED;
            end
          end
`endif
          default: begin
            state   <= ST_DISARMED;
            ringing <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
